// File: rtl/dm_access_ctrl.sv
// Load/store initiator: turns byte/half/word requests into word accesses, with RMW for sub-word stores.
// Latency accept->resp: errors 1, loads/SW 2, SH/SB 3; RESP holds until resp_ready, req_ready only in IDLE.
module dm_access_ctrl #(
   parameter int DM_WORDS = 3072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        dm_we,
   input  logic [31:0] dm_rdata
);
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   localparam logic [31:0] ADDR_LIMIT = 32'(DM_WORDS * 4);

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic [1:0]  err_q, err_d;

   logic [1:0]  req_err;
   logic        is_load;
   logic [31:0] word_addr;
   logic [31:0] merged;
   logic [31:0] lane_data;
   logic [15:0] lane_h;
   logic [7:0]  lane_b;

   // Misalignment outranks the range check when both apply.
   always_comb begin
      req_err = 2'b00;
      if (((req_op == OP_LW || req_op == OP_SW) && req_addr[1:0] != 2'b00) ||
          ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0])) begin
         req_err = 2'b01;
      end else if (req_addr >= ADDR_LIMIT) begin
         req_err = 2'b10;
      end
   end

   assign is_load   = (op_q <= OP_LBU);
   assign word_addr = {addr_q[31:2], 2'b00};

   always_comb begin
      merged = buf_q;
      case (op_q)
         OP_SW: merged = wdata_q;
         OP_SH: begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
         end
         OP_SB: begin
            case (addr_q[1:0])
               2'd0:    merged[7:0]   = wdata_q[7:0];
               2'd1:    merged[15:8]  = wdata_q[7:0];
               2'd2:    merged[23:16] = wdata_q[7:0];
               default: merged[31:24] = wdata_q[7:0];
            endcase
         end
         default: merged = buf_q;
      endcase
   end

   always_comb begin
      lane_h = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
      case (addr_q[1:0])
         2'd0:    lane_b = buf_q[7:0];
         2'd1:    lane_b = buf_q[15:8];
         2'd2:    lane_b = buf_q[23:16];
         default: lane_b = buf_q[31:24];
      endcase
      case (op_q)
         OP_LH:   lane_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  lane_data = {16'h0000, lane_h};
         OP_LB:   lane_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  lane_data = {24'h000000, lane_b};
         default: lane_data = buf_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         buf_q   <= 32'd0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 2'b00;
      dm_addr    = 32'd0;
      dm_wdata   = 32'd0;
      dm_we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = req_err;
               if (req_err != 2'b00)  state_d = ST_RESP;
               else if (req_op == OP_SW) state_d = ST_WRITE;
               else                   state_d = ST_READ;
            end
         end
         ST_READ: begin
            dm_addr = word_addr;
            buf_d   = dm_rdata;
            state_d = is_load ? ST_RESP : ST_WRITE;
         end
         ST_WRITE: begin
            // Merge uses the buffered word, never the live read port.
            dm_addr  = word_addr;
            dm_wdata = merged;
            dm_we    = 1'b1;
            state_d  = ST_RESP;
         end
         default: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (is_load && err_q == 2'b00) ? lane_data : 32'd0;
            if (resp_ready) state_d = ST_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: word memory model, per-request expectation model and a per-cycle output comparator.
module tb_dm_access_ctrl;
   localparam int DM_WORDS = 3072;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_we;
   logic [31:0] dm_rdata;

   dm_access_ctrl #(.DM_WORDS(DM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   // Environment memory seen by the DUT; read data is inverted during a write cycle.
   logic [31:0] mem [DM_WORDS];
   logic        tb_we = 1'b0;
   int          tb_idx = 0;
   logic [31:0] tb_val = 32'd0;

   always_comb begin
      dm_rdata = 32'd0;
      if (int'(dm_addr[31:2]) < DM_WORDS) dm_rdata = mem[int'(dm_addr[31:2])];
      if (dm_we) dm_rdata = ~dm_rdata;
   end

   always @(posedge clk) begin
      if (dm_we && int'(dm_addr[31:2]) < DM_WORDS) mem[int'(dm_addr[31:2])] <= dm_wdata;
      else if (tb_we) mem[tb_idx] <= tb_val;
   end

   // Model state
   logic [31:0] ref_mem [DM_WORDS];
   bit          active = 1'b0;
   int          cyc = 0;
   int          exp_lat, exp_rd_cyc, exp_we_cyc;
   logic [31:0] exp_word_addr, exp_wdata, exp_rdata;
   logic [1:0]  exp_err;
   logic [31:0] last_rdata;
   logic [1:0]  last_err;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] word, bval, hval, m;
      int          sb, sh, idx;
      bit          mis, oor;
      idx  = int'(addr[31:2]);
      word = (idx < DM_WORDS) ? ref_mem[idx] : 32'd0;
      sb   = 8 * int'(addr[1:0]);
      sh   = 16 * int'(addr[1]);
      bval = (word >> sb) & 32'hFF;
      hval = (word >> sh) & 32'hFFFF;
      mis  = ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'd0) ||
             ((op == 3'd1 || op == 3'd2 || op == 3'd6) && addr[0]);
      oor  = addr >= 32'(DM_WORDS * 4);
      exp_err = mis ? 2'b01 : (oor ? 2'b10 : 2'b00);
      exp_word_addr = {addr[31:2], 2'b00};
      exp_rdata = 32'd0;
      exp_wdata = 32'd0;
      if (exp_err != 2'b00) begin
         exp_lat = 1; exp_rd_cyc = 0; exp_we_cyc = 0;
      end else if (op == 3'd5) begin
         exp_lat = 2; exp_rd_cyc = 0; exp_we_cyc = 1;
      end else if (op >= 3'd6) begin
         exp_lat = 3; exp_rd_cyc = 1; exp_we_cyc = 2;
      end else begin
         exp_lat = 2; exp_rd_cyc = 1; exp_we_cyc = 0;
      end
      if (exp_err == 2'b00) begin
         case (op)
            3'd0: exp_rdata = word;
            3'd1: exp_rdata = (hval >= 32'h8000) ? (hval | 32'hFFFF0000) : hval;
            3'd2: exp_rdata = hval;
            3'd3: exp_rdata = (bval >= 32'h80) ? (bval | 32'hFFFFFF00) : bval;
            3'd4: exp_rdata = bval;
            3'd5: exp_wdata = wd;
            3'd6: begin
               m = 32'hFFFF << sh;
               exp_wdata = (word & ~m) | ((wd & 32'hFFFF) << sh);
            end
            default: begin
               m = 32'hFF << sb;
               exp_wdata = (word & ~m) | ((wd & 32'hFF) << sb);
            end
         endcase
      end
   endtask

   // Per-cycle comparator against the scheduled expectations.
   logic        e_rv, e_we;
   logic [31:0] e_addr;
   always @(negedge clk) begin
      e_rv   = active && cyc >= exp_lat;
      e_we   = active && cyc == exp_we_cyc;
      e_addr = (active && (cyc == exp_rd_cyc || cyc == exp_we_cyc)) ? exp_word_addr : 32'd0;
      check("req_ready",  32'(req_ready),  32'(!active));
      check("resp_valid", 32'(resp_valid), 32'(e_rv));
      check("resp_rdata", resp_rdata, e_rv ? exp_rdata : 32'd0);
      check("resp_err",   32'(resp_err),  e_rv ? 32'(exp_err) : 32'd0);
      check("dm_we",      32'(dm_we),     32'(e_we));
      check("dm_addr",    dm_addr, e_addr);
      check("dm_wdata",   dm_wdata, e_we ? exp_wdata : 32'd0);
   end

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      tb_we = 1'b1; tb_idx = idx; tb_val = val;
      ref_mem[idx] = val;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int stall, input bit hold_valid, input int abort_at);
      bit got, leaving;
      int waited, guard;
      model(op, addr, wd);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      resp_ready = (stall == 0);
      @(posedge clk);
      active = 1'b1; cyc = 1;
      got = 1'b0; waited = 0; guard = 0;
      while (active && guard < 64) begin
         guard++;
         leaving = 1'b0;
         if (abort_at == cyc) begin
            #2;
            reset = 1'b1; req_valid = 1'b0; active = 1'b0;
            #1;
            check("abort_resp_valid", 32'(resp_valid), 32'd0);
            check("abort_dm_we",      32'(dm_we),      32'd0);
            check("abort_req_ready",  32'(req_ready),  32'd1);
            check("abort_dm_addr",    dm_addr,         32'd0);
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            break;
         end
         @(negedge clk);
         if (!hold_valid) req_valid = 1'b0;
         if (cyc >= exp_lat) begin
            if (!got) begin
               got = 1'b1; last_rdata = resp_rdata; last_err = resp_err;
            end
            if (waited >= stall) begin
               resp_ready = 1'b1; req_valid = 1'b0; leaving = 1'b1;
            end else begin
               resp_ready = 1'b0;
            end
            waited++;
         end
         @(posedge clk);
         if (leaving) begin
            active = 1'b0;
            if (exp_we_cyc != 0) ref_mem[int'(addr[31:2])] = exp_wdata;
         end else begin
            cyc++;
         end
      end
      if (active) begin
         check("request_timeout", 32'd1, 32'd0);
         active = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0;
      req_wdata = 32'd0; resp_ready = 1'b0;
      last_rdata = 32'd0; last_err = 2'b00;
      exp_lat = 1; exp_rd_cyc = 0; exp_we_cyc = 0;
      exp_word_addr = 32'd0; exp_wdata = 32'd0; exp_rdata = 32'd0; exp_err = 2'b00;
      for (int i = 0; i < DM_WORDS; i++) ref_mem[i] = 32'd0;
      #12;
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_dm_we",      32'(dm_we),      32'd0);
      check("rst_dm_wdata",   dm_wdata,        32'd0);
      @(negedge clk);
      reset = 1'b0;
      poke(4, 32'h11223344);

      // Reset asserted mid-cycle while a stalled LW sits in RESP.
      run_req(3'd0, 32'h10, 32'd0, 3, 1'b0, 2);
      check("after_abort_mem4", mem[4], 32'h11223344);

      run_req(3'd7, 32'h11, 32'h000000AB, 0, 1'b0, 0);
      check("model_sb_wdata", exp_wdata, 32'h1122AB44);
      check("sb_mem4", mem[4], 32'h1122AB44);
      check("sb_err", 32'(last_err), 32'd0);

      run_req(3'd3, 32'h11, 32'd0, 0, 1'b0, 0);
      check("lb_0x11", last_rdata, 32'hFFFFFFAB);
      run_req(3'd4, 32'h11, 32'd0, 0, 1'b0, 0);
      check("lbu_0x11", last_rdata, 32'h000000AB);
      run_req(3'd1, 32'h12, 32'd0, 0, 1'b0, 0);
      check("lh_0x12", last_rdata, 32'h00001122);
      run_req(3'd1, 32'h10, 32'd0, 0, 1'b0, 0);
      check("lh_0x10_sext", last_rdata, 32'hFFFFAB44);
      run_req(3'd2, 32'h10, 32'd0, 0, 1'b0, 0);
      check("lhu_0x10", last_rdata, 32'h0000AB44);
      run_req(3'd0, 32'h10, 32'd0, 0, 1'b0, 0);
      check("lw_0x10", last_rdata, 32'h1122AB44);

      run_req(3'd0, 32'h0102, 32'd0, 0, 1'b0, 0);
      check("lw_misaligned_err", 32'(last_err), 32'd1);
      run_req(3'd6, 32'h0003, 32'h1234, 0, 1'b0, 0);
      check("sh_misaligned_err", 32'(last_err), 32'd1);
      run_req(3'd0, 32'h3001, 32'd0, 0, 1'b0, 0);
      check("both_errs_misaligned_wins", 32'(last_err), 32'd1);
      run_req(3'd5, 32'h3000, 32'h01020304, 0, 1'b0, 0);
      check("sw_range_err", 32'(last_err), 32'd2);
      run_req(3'd4, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, 0);
      check("lbu_range_err", 32'(last_err), 32'd2);

      run_req(3'd5, 32'h2FFC, 32'hDEADBEEF, 0, 1'b0, 0);
      check("sw_last_word_mem", mem[3071], 32'hDEADBEEF);
      check("sw_last_word_err", 32'(last_err), 32'd0);

      run_req(3'd0, 32'h2FFC, 32'd0, 5, 1'b1, 0);
      check("lw_stalled", last_rdata, 32'hDEADBEEF);

      run_req(3'd6, 32'h12, 32'h00005566, 0, 1'b0, 0);
      check("sh_mem4", mem[4], 32'h5566AB44);
      run_req(3'd3, 32'h13, 32'd0, 0, 1'b0, 0);
      check("lb_0x13", last_rdata, 32'h00000055);

      // Reset during the READ of an SB: memory must stay as it was.
      run_req(3'd7, 32'h10, 32'h00000099, 0, 1'b0, 1);
      check("sb_abort_mem4", mem[4], 32'h5566AB44);
      check("sb_abort_ref", mem[4], ref_mem[4]);

      run_req(3'd0, 32'h10, 32'd0, 0, 1'b0, 0);
      check("lw_after_abort", last_rdata, 32'h5566AB44);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Load/store initiator that sits between the pipeline's memory stage and the word-addressed data memory. The data memory reads combinationally and writes a full word on the clock edge. This block turns byte, halfword and word loads and stores into word accesses:
- sub-word stores become a read-modify-write sequence;
- loads are lane-extracted and sign- or zero-extended;
- misaligned and out-of-range accesses are rejected before memory is touched.

Requests and responses use valid/ready handshakes, and one request is in flight at a time.

## Interface
Parameters:
- `DM_WORDS`, 3072: data memory depth in 32-bit words. The valid byte range is 0 .. `DM_WORDS*4-1`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: a request is presented.
- `req_ready`, output, 1: the block can accept a request. High only in IDLE.
- `req_op`, input, 3: operation code. 0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5=SW, 6=SH, 7=SB.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data. SB uses bits [7:0]; SH uses bits [15:0].
- `resp_valid`, output, 1: a response is available.
- `resp_ready`, input, 1: the consumer accepts the response.
- `resp_rdata`, output, 32: extended load data. Always 0 for stores and errors.
- `resp_err`, output, 2: 00 ok, 01 misaligned, 10 out of range.
- `dm_addr`, output, 32: word-aligned address to the data memory.
- `dm_wdata`, output, 32: write data to the data memory.
- `dm_we`, output, 1: data memory write enable.
- `dm_rdata`, input, 32: combinational read data from the data memory.

## Operation
- **State machine:** IDLE, READ, WRITE, RESP.
- **IDLE**
  - On `req_valid`&&`req_ready`, latch op, addr and wdata.
  - Alignment check:
    - word ops need addr[1:0]==0;
    - half ops need addr[0]==0;
    - byte ops always pass.
  - Range check: addr >= `DM_WORDS*4` fails. If both checks fail, misaligned takes priority.
  - On an error, go to RESP with `resp_err` set. No memory access is made.
  - Otherwise SW goes to WRITE; every load, and SH/SB, goes to READ.
- **READ**
  - Register `dm_rdata` into the word buffer.
  - Loads go to RESP; SH/SB go to WRITE.
- **WRITE**
  - `dm_we`=1 for exactly this one cycle.
  - `dm_wdata` selection:
    - SW: latched wdata.
    - SH: buffer with half addr[1] replaced by wdata[15:0].
    - SB: buffer with byte addr[1:0] replaced by wdata[7:0].
  - Next state is RESP.
- **RESP**
  - `resp_valid`=1, and `resp_rdata`/`resp_err` are held stable until `resp_ready`.
  - On that edge go to IDLE.
- **Lane extraction for loads:** little-endian; byte 0 = bits [7:0], half 0 = bits [15:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW returns the buffer unchanged.
- **Memory-side outputs:**
  - `dm_addr` = {latched addr[31:2], 2'b00} in READ and WRITE, 0 otherwise.
  - `dm_wdata` = 0 outside WRITE.
  - `dm_we` is never high outside WRITE and never high for an errored request.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=00, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0.
- **Latency**, counted from the accept edge (cycle 0) to the first cycle `resp_valid` is high:
  - loads and SW: 2 cycles;
  - SH/SB: 3 cycles;
  - errored requests: 1 cycle.
- **Throughput:** `resp_ready` high in the first RESP cycle leaves RESP on that edge. The next request can be accepted one cycle later, in IDLE; `req_ready` is 0 throughout RESP. A held `resp_ready`=0 stalls indefinitely in RESP with outputs stable.
- **Requests outside IDLE:** ignored, because `req_ready`=0. No input is sampled.
- **Memory-side timing:** the data memory commits the write at the rising edge that ends WRITE.
- **Reset mid-operation:**
  - reset immediately forces IDLE and drops `dm_we` and `resp_valid`;
  - a write is committed only if its WRITE cycle completed before reset rose;
  - the response of the aborted request is never delivered.
- **Buffer isolation:** for SH/SB the word buffer holds the value read in READ. Changes to `dm_rdata` during WRITE do not alter the merge.

## Test plan
- **Reset:** memory word 0x10 = 0x11223344. Assert `reset` asynchronously mid-cycle → all outputs take their reset values immediately and `req_ready`=1.
- **Byte store:** memory word 0x10 = 0x11223344. SB addr 0x11, wdata 0xAB → read at cycle 1, `dm_we` in cycle 2 with `dm_wdata` 0x1122AB44, `resp_valid` in cycle 3 with err 00.
- **Byte loads:** memory word 0x10 = 0x1122AB44. LB addr 0x11 → `resp_rdata` 0xFFFFFFAB. LBU addr 0x11 → 0x000000AB. LH addr 0x12 → 0x00001122.
- **Alignment errors:** LW addr 0x0102 → err 01, `dm_we` never high, response in cycle 1. SH addr 0x0003 → err 01.
- **Range error:** with `DM_WORDS`=3072, SW addr 0x3000 → err 10 and no write. SW addr 0x2FFC, wdata 0xDEADBEEF → `dm_we` in cycle 1, err 00.
- **Backpressure and reset abort:**
  - Hold `resp_ready`=0 for 5 cycles during an LW → `resp_valid` and `resp_rdata` stay stable, and `req_valid` held high is not accepted.
  - Assert reset during the READ of an SB → no `dm_we` pulse, and memory is unchanged.
